tlb_lookup_unit: RTL and testbench

//  Parametrised fully-associative MIPS32 joint TLB that owns its entry storage. Lookups are registered.

---
 rtl/tlb_pkg.sv | 32 +++
 rtl/tlb_match_port.sv | 65 ++++++
 rtl/tlb_lookup_unit.sv | 249 ++++++++++++++++++++++++
 tb/tb_tlb_lookup_unit.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
// Shared types and constants for the MIPS32 joint TLB.
// Optional feature macro used by the TLB files: TLB_MULTIHIT_EN.
package tlb_pkg;

  localparam int VPN2_W = 19;
  localparam int ASID_W = 8;
  localparam int PFN_W  = 20;

  // kseg0/kseg1 share the top two address bits; bit 29 separates them
  localparam logic [1:0] KSEG01_TOP = 2'b10;
  localparam logic [2:0] C_UNCACHED = 3'd2;
  localparam logic [2:0] C_CACHED   = 3'd3;

  typedef struct packed {
    logic [VPN2_W-1:0] vpn2;
    logic [ASID_W-1:0] asid;
    logic              g;
    logic [PFN_W-1:0]  pfn1;
    logic [2:0]        c1;
    logic              d1;
    logic              v1;
    logic [PFN_W-1:0]  pfn0;
    logic [2:0]        c0;
    logic              d0;
    logic              v0;
  } tlb_entry_t;

  function automatic logic is_unmapped(input logic [31:0] vaddr);
    return vaddr[31:30] == KSEG01_TOP;
  endfunction

endpackage

// File: rtl/tlb_match_port.sv
// Combinational matcher for one translation channel (also reused as the TLBP probe matcher).
// Compares every entry, picks the lowest matching index, selects the even/odd page and flags faults.
module tlb_match_port
  import tlb_pkg::*;
#(
  parameter  int NUM_ENTRIES = 16,
  localparam int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  tlb_entry_t [NUM_ENTRIES-1:0] entries,
  input  logic [VPN2_W-1:0]            vpn2,
  input  logic [ASID_W-1:0]            asid,
  input  logic                         odd,
  input  logic                         store,
  output logic                         hit,
  output logic [IDX_W-1:0]             index,
  output logic                         multi,
  output logic [PFN_W-1:0]             pfn,
  output logic [2:0]                   cache,
  output logic                         miss,
  output logic                         invalid,
  output logic                         modified
);

  logic [NUM_ENTRIES-1:0] match;
  tlb_entry_t             sel;
  logic                   page_v;
  logic                   page_d;

  // Per-entry tag compare: VPN2 must match and either the entry is global or the ASID agrees
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      match[i] = (entries[i].vpn2 == vpn2) && (entries[i].g || (entries[i].asid == asid));
    end
  end

  // Priority encoder: scanning downwards lets the lowest matching index overwrite the rest
  always_comb begin
    hit   = 1'b0;
    index = '0;
    sel   = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit   = 1'b1;
        index = IDX_W'(i);
        sel   = entries[i];
      end
    end
  end

  // More than one bit set means clearing the lowest set bit leaves something behind
  assign multi = |(match & (match - NUM_ENTRIES'(1)));

  // Page select and fault classification; only one fault can be reported at a time
  always_comb begin
    pfn      = odd ? sel.pfn1 : sel.pfn0;
    cache    = odd ? sel.c1   : sel.c0;
    page_v   = odd ? sel.v1   : sel.v0;
    page_d   = odd ? sel.d1   : sel.d0;
    miss     = !hit;
    invalid  = hit && !page_v;
    modified = hit && page_v && store && !page_d;
  end

endmodule

// File: rtl/tlb_lookup_unit.sv
// Fully-associative MIPS32 joint TLB with registered multi-port lookup, TLBWI/TLBWR, TLBR and TLBP.
// Optional feature macro: TLB_MULTIHIT_EN (adds the mc_err machine-check output).
module tlb_lookup_unit
  import tlb_pkg::*;
#(
  parameter  int NUM_ENTRIES = 16,
  parameter  int NUM_PORTS   = 2,
  parameter  int PA_W        = 32,
  localparam int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ASID_W-1:0]         asid,
  input  logic [NUM_PORTS-1:0]      lk_valid,
  input  logic [NUM_PORTS*32-1:0]   lk_vaddr,
  input  logic [NUM_PORTS-1:0]      lk_store,
  output logic [NUM_PORTS-1:0]      lk_ready,
  output logic [NUM_PORTS-1:0]      rs_valid,
  output logic [NUM_PORTS*PA_W-1:0] rs_paddr,
  output logic [NUM_PORTS-1:0]      rs_miss,
  output logic [NUM_PORTS-1:0]      rs_invalid,
  output logic [NUM_PORTS-1:0]      rs_modified,
  output logic [NUM_PORTS*3-1:0]    rs_cache,
  input  logic                      wr_en,
  input  logic                      wr_random,
  input  logic [IDX_W-1:0]          wr_index,
  input  tlb_entry_t                wr_entry,
  input  logic [IDX_W-1:0]          rd_index,
  output tlb_entry_t                rd_entry,
  input  logic                      pr_en,
  input  logic [VPN2_W-1:0]         pr_vpn2,
  output logic                      pr_done,
  output logic                      pr_hit,
  output logic [IDX_W-1:0]          pr_index,
  input  logic [IDX_W-1:0]          wired,
  input  logic                      wired_wr,
  output logic [IDX_W-1:0]          random_o
`ifdef TLB_MULTIHIT_EN
  ,
  output logic                      mc_err
`endif
);

  localparam logic [IDX_W-1:0] RAND_MAX = IDX_W'(NUM_ENTRIES - 1);

  tlb_entry_t [NUM_ENTRIES-1:0] tlb_q;
  logic [IDX_W-1:0]             wr_idx;

  logic [NUM_PORTS-1:0] acc;
  logic [NUM_PORTS-1:0] unmapped;
  logic [NUM_PORTS-1:0] pm_hit;
  logic [NUM_PORTS-1:0] pm_multi;
  logic [NUM_PORTS-1:0] pm_miss;
  logic [NUM_PORTS-1:0] pm_invalid;
  logic [NUM_PORTS-1:0] pm_modified;
  logic [IDX_W-1:0]     pm_index [NUM_PORTS];
  logic [PFN_W-1:0]     pm_pfn   [NUM_PORTS];
  logic [2:0]           pm_cache [NUM_PORTS];

  logic [NUM_PORTS-1:0] nxt_miss;
  logic [NUM_PORTS-1:0] nxt_invalid;
  logic [NUM_PORTS-1:0] nxt_modified;
  logic [PA_W-1:0]      nxt_paddr [NUM_PORTS];
  logic [2:0]           nxt_cache [NUM_PORTS];

  logic             prm_hit;
  logic [IDX_W-1:0] prm_index;
  logic             prm_multi_unused;
  logic [PFN_W-1:0] prm_pfn_unused;
  logic [2:0]       prm_cache_unused;
  logic             prm_miss_unused;
  logic             prm_invalid_unused;
  logic             prm_modified_unused;

  // A write stalls every lookup port for its cycle so lookups never race the entry update
  assign lk_ready = {NUM_PORTS{!wr_en}};
  assign wr_idx   = wr_random ? random_o : wr_index;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    tlb_match_port #(.NUM_ENTRIES(NUM_ENTRIES)) u_match (
      .entries  (tlb_q),
      .vpn2     (lk_vaddr[p*32+13 +: VPN2_W]),
      .asid     (asid),
      .odd      (lk_vaddr[p*32+12]),
      .store    (lk_store[p]),
      .hit      (pm_hit[p]),
      .index    (pm_index[p]),
      .multi    (pm_multi[p]),
      .pfn      (pm_pfn[p]),
      .cache    (pm_cache[p]),
      .miss     (pm_miss[p]),
      .invalid  (pm_invalid[p]),
      .modified (pm_modified[p])
    );
  end

  tlb_match_port #(.NUM_ENTRIES(NUM_ENTRIES)) u_probe (
    .entries  (tlb_q),
    .vpn2     (pr_vpn2),
    .asid     (asid),
    .odd      (1'b0),
    .store    (1'b0),
    .hit      (prm_hit),
    .index    (prm_index),
    .multi    (prm_multi_unused),
    .pfn      (prm_pfn_unused),
    .cache    (prm_cache_unused),
    .miss     (prm_miss_unused),
    .invalid  (prm_invalid_unused),
    .modified (prm_modified_unused)
  );

  // Build each port's next response: kseg0/kseg1 bypass the TLB, any fault zeroes the address
  always_comb begin
    acc          = lk_valid & ~{NUM_PORTS{wr_en}};
    unmapped     = '0;
    nxt_miss     = '0;
    nxt_invalid  = '0;
    nxt_modified = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      nxt_paddr[p] = '0;
      nxt_cache[p] = '0;
      unmapped[p]  = is_unmapped(lk_vaddr[p*32 +: 32]);
      if (acc[p]) begin
        if (unmapped[p]) begin
          nxt_paddr[p] = PA_W'(lk_vaddr[p*32 +: 29]);
          nxt_cache[p] = lk_vaddr[p*32+29] ? C_UNCACHED : C_CACHED;
        end else begin
          nxt_miss[p]     = pm_miss[p];
          nxt_invalid[p]  = pm_invalid[p];
          nxt_modified[p] = pm_modified[p];
          if (!(pm_miss[p] || pm_invalid[p] || pm_modified[p])) begin
            nxt_paddr[p] = PA_W'({pm_pfn[p], lk_vaddr[p*32 +: 12]});
            nxt_cache[p] = pm_cache[p];
          end
        end
      end
    end
  end

  // Response registers: valid exactly one cycle after acceptance, all zero otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_valid    <= '0;
      rs_miss     <= '0;
      rs_invalid  <= '0;
      rs_modified <= '0;
      rs_paddr    <= '0;
      rs_cache    <= '0;
    end else begin
      rs_valid    <= acc;
      rs_miss     <= nxt_miss;
      rs_invalid  <= nxt_invalid;
      rs_modified <= nxt_modified;
      for (int p = 0; p < NUM_PORTS; p++) begin
        rs_paddr[p*PA_W +: PA_W] <= nxt_paddr[p];
        rs_cache[p*3 +: 3]       <= nxt_cache[p];
      end
    end
  end

  // Entry storage; TLBWR uses the Random value current in the write cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tlb_q <= '0;
    end else if (wr_en) begin
      tlb_q[wr_idx] <= wr_entry;
    end
  end

  // TLBR read port; sees pre-write contents when a write happens in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_entry <= '0;
    end else begin
      rd_entry <= tlb_q[rd_index];
    end
  end

  // TLBP result; reports index 0 on a miss
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pr_done  <= 1'b0;
      pr_hit   <= 1'b0;
      pr_index <= '0;
    end else begin
      pr_done  <= pr_en;
      pr_hit   <= pr_en && prm_hit;
      pr_index <= (pr_en && prm_hit) ? prm_index : '0;
    end
  end

  // Random counts down and reloads the top index once the next step would reach Wired
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      random_o <= RAND_MAX;
    end else if (wired_wr || (wired >= RAND_MAX)) begin
      random_o <= RAND_MAX;
    end else if ({1'b0, random_o} <= ({1'b0, wired} + (IDX_W+1)'(1))) begin
      random_o <= RAND_MAX;
    end else begin
      random_o <= random_o - IDX_W'(1);
    end
  end

`ifdef TLB_MULTIHIT_EN
  logic mc_pulse_q;
  logic mc_sticky_q;
  logic wr_dup;

  // A write duplicates an existing mapping if another slot would match the same VPN2/ASID
  always_comb begin
    wr_dup = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if ((IDX_W'(i) != wr_idx) && (tlb_q[i].vpn2 == wr_entry.vpn2) &&
          (tlb_q[i].g || wr_entry.g || (tlb_q[i].asid == wr_entry.asid))) begin
        wr_dup = 1'b1;
      end
    end
  end

  // Machine check: pulse on a multi-hit lookup, latch forever on a duplicate-creating write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mc_pulse_q  <= 1'b0;
      mc_sticky_q <= 1'b0;
    end else begin
      mc_pulse_q <= |(acc & ~unmapped & pm_multi);
      if (wr_en && wr_dup) begin
        mc_sticky_q <= 1'b1;
      end
    end
  end

  assign mc_err = mc_pulse_q || mc_sticky_q;
`else
  logic multi_unused;
  assign multi_unused = |pm_multi;
`endif

  logic port_unused;
  always_comb begin
    port_unused = |pm_hit;
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_unused = port_unused ^ (|pm_index[p]);
    end
  end

endmodule

// File: tb/tb_tlb_lookup_unit.sv
// Directed self-checking bench for tlb_lookup_unit (default parameters: 16 entries, 2 ports, 32-bit PA).
// Build with TLB_MULTIHIT_EN defined to also exercise mc_err.
module tb_tlb_lookup_unit;
  import tlb_pkg::*;

  localparam int NE = 16;
  localparam int NP = 2;
  localparam int IW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [7:0]      asid;
  logic [NP-1:0]   lk_valid;
  logic [NP*32-1:0] lk_vaddr;
  logic [NP-1:0]   lk_store;
  logic [NP-1:0]   lk_ready;
  logic [NP-1:0]   rs_valid;
  logic [NP*32-1:0] rs_paddr;
  logic [NP-1:0]   rs_miss;
  logic [NP-1:0]   rs_invalid;
  logic [NP-1:0]   rs_modified;
  logic [NP*3-1:0] rs_cache;
  logic            wr_en;
  logic            wr_random;
  logic [IW-1:0]   wr_index;
  tlb_entry_t      wr_entry;
  logic [IW-1:0]   rd_index;
  tlb_entry_t      rd_entry;
  logic            pr_en;
  logic [18:0]     pr_vpn2;
  logic            pr_done;
  logic            pr_hit;
  logic [IW-1:0]   pr_index;
  logic [IW-1:0]   wired;
  logic            wired_wr;
  logic [IW-1:0]   random_o;
`ifdef TLB_MULTIHIT_EN
  logic            mc_err;
`endif

  int errors = 0;
  int checks = 0;

  tlb_entry_t e2, e3, e5, e7, e13, e1;

  tlb_lookup_unit #(.NUM_ENTRIES(NE), .NUM_PORTS(NP), .PA_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .asid        (asid),
    .lk_valid    (lk_valid),
    .lk_vaddr    (lk_vaddr),
    .lk_store    (lk_store),
    .lk_ready    (lk_ready),
    .rs_valid    (rs_valid),
    .rs_paddr    (rs_paddr),
    .rs_miss     (rs_miss),
    .rs_invalid  (rs_invalid),
    .rs_modified (rs_modified),
    .rs_cache    (rs_cache),
    .wr_en       (wr_en),
    .wr_random   (wr_random),
    .wr_index    (wr_index),
    .wr_entry    (wr_entry),
    .rd_index    (rd_index),
    .rd_entry    (rd_entry),
    .pr_en       (pr_en),
    .pr_vpn2     (pr_vpn2),
    .pr_done     (pr_done),
    .pr_hit      (pr_hit),
    .pr_index    (pr_index),
    .wired       (wired),
    .wired_wr    (wired_wr),
    .random_o    (random_o)
`ifdef TLB_MULTIHIT_EN
    ,
    .mc_err      (mc_err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  function automatic tlb_entry_t mkEntry(
    input logic [18:0] vpn2, input logic [7:0] easid, input logic g,
    input logic [19:0] pfn1, input logic [2:0] c1, input logic d1, input logic v1,
    input logic [19:0] pfn0, input logic [2:0] c0, input logic d0, input logic v0);
    tlb_entry_t e;
    e.vpn2 = vpn2; e.asid = easid; e.g = g;
    e.pfn1 = pfn1; e.c1 = c1; e.d1 = d1; e.v1 = v1;
    e.pfn0 = pfn0; e.c0 = c0; e.d0 = d0; e.v0 = v0;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One-cycle lookup on a port; the response is registered by the time this returns
  task automatic applyStimulus(input int port, input logic [31:0] vaddr, input logic store);
    lk_valid[port]          = 1'b1;
    lk_store[port]          = store;
    lk_vaddr[port*32 +: 32] = vaddr;
    tick();
    lk_valid[port] = 1'b0;
    lk_store[port] = 1'b0;
  endtask

  task automatic writeEntry(input logic [IW-1:0] idx, input logic rnd, input tlb_entry_t e);
    wr_en     = 1'b1;
    wr_random = rnd;
    wr_index  = idx;
    wr_entry  = e;
    tick();
    wr_en     = 1'b0;
    wr_random = 1'b0;
  endtask

  task automatic checkLookup(input string tag, input int port, input logic [31:0] paddr,
                             input logic [2:0] cache, input logic miss, input logic inv, input logic mod);
    checkOutput({tag, ".valid"},    128'(rs_valid[port]),         128'(1'b1));
    checkOutput({tag, ".miss"},     128'(rs_miss[port]),          128'(miss));
    checkOutput({tag, ".invalid"},  128'(rs_invalid[port]),       128'(inv));
    checkOutput({tag, ".modified"}, 128'(rs_modified[port]),      128'(mod));
    checkOutput({tag, ".paddr"},    128'(rs_paddr[port*32 +: 32]), 128'(paddr));
    if (!(miss || inv || mod)) begin
      checkOutput({tag, ".cache"}, 128'(rs_cache[port*3 +: 3]), 128'(cache));
    end
  endtask

  initial begin
    rst_n = 1'b0; asid = '0; lk_valid = '0; lk_vaddr = '0; lk_store = '0;
    wr_en = 1'b0; wr_random = 1'b0; wr_index = '0; wr_entry = '0;
    rd_index = '0; pr_en = 1'b0; pr_vpn2 = '0; wired = '0; wired_wr = 1'b0;

    e2  = mkEntry(19'h00200, 8'd0, 1'b1, 20'h12345, 3'd3, 1'b1, 1'b1, 20'h00000, 3'd0, 1'b0, 1'b0);
    e3  = mkEntry(19'h00200, 8'd5, 1'b0, 20'h12345, 3'd3, 1'b1, 1'b1, 20'h00ABC, 3'd2, 1'b0, 1'b1);
    e5  = mkEntry(19'h00300, 8'd0, 1'b1, 20'h0F0F0, 3'd3, 1'b1, 1'b0, 20'h0F0F0, 3'd3, 1'b1, 1'b0);
    e7  = mkEntry(19'h00400, 8'd0, 1'b1, 20'h00000, 3'd0, 1'b0, 1'b0, 20'h55555, 3'd3, 1'b1, 1'b1);
    e13 = mkEntry(19'h00500, 8'd0, 1'b1, 20'h00000, 3'd0, 1'b0, 1'b0, 20'h0ABCD, 3'd3, 1'b1, 1'b1);
    e1  = mkEntry(19'h00400, 8'd0, 1'b1, 20'h00000, 3'd0, 1'b0, 1'b0, 20'h11111, 3'd3, 1'b1, 1'b1);

    // Reset state
    tick(); tick(); tick();
    checkOutput("reset.random", 128'(random_o), 128'(15));
    checkOutput("reset.rs_valid", 128'(rs_valid), 128'(0));
    checkOutput("reset.rd_entry", 128'(rd_entry), 128'(0));
    checkOutput("reset.pr_done", 128'(pr_done), 128'(0));
`ifdef TLB_MULTIHIT_EN
    checkOutput("reset.mc_err", 128'(mc_err), 128'(0));
`endif
    rst_n = 1'b1;
    tick();

    // Empty TLB: mapped lookup misses
    applyStimulus(0, 32'h0040_1000, 1'b0);
    checkLookup("empty_miss", 0, 32'h0, 3'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("empty_miss.p1_idle", 128'(rs_valid[1]), 128'(0));
    tick();
    checkOutput("rs_valid_drops", 128'(rs_valid), 128'(0));

    // TLBWI global entry at index 3, then lookup + TLBR + TLBP together
    writeEntry(4'd3, 1'b0, e2);
    rd_index = 4'd3; pr_en = 1'b1; pr_vpn2 = 19'h00200;
    applyStimulus(1, 32'h0040_1ABC, 1'b0);
    pr_en = 1'b0;
    checkLookup("global_hit", 1, 32'h1234_5ABC, 3'd3, 1'b0, 1'b0, 1'b0);
    checkOutput("tlbr_idx3", 128'(rd_entry), 128'(e2));
    checkOutput("probe.done", 128'(pr_done), 128'(1));
    checkOutput("probe.hit", 128'(pr_hit), 128'(1));
    checkOutput("probe.index", 128'(pr_index), 128'(3));

    // Non-global entry: ASID mismatch misses, store to clean page faults, load translates
    writeEntry(4'd3, 1'b0, e3);
    asid = 8'd6;
    pr_en = 1'b1; pr_vpn2 = 19'h00200;
    applyStimulus(0, 32'h0040_1ABC, 1'b0);
    pr_en = 1'b0;
    checkLookup("asid_miss", 0, 32'h0, 3'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("probe_miss.hit", 128'(pr_hit), 128'(0));
    checkOutput("probe_miss.index", 128'(pr_index), 128'(0));
    asid = 8'd5;
    applyStimulus(0, 32'h0040_0010, 1'b1);
    checkLookup("store_modified", 0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(0, 32'h0040_0010, 1'b0);
    checkLookup("even_load", 0, 32'h00AB_C010, 3'd2, 1'b0, 1'b0, 1'b0);

    // Invalid page
    writeEntry(4'd5, 1'b0, e5);
    applyStimulus(1, 32'h0060_0000, 1'b0);
    checkLookup("invalid_page", 1, 32'h0, 3'd0, 1'b0, 1'b1, 1'b0);

    // Write stalls a concurrent lookup; the retried lookup sees the new entry
    lk_valid[0] = 1'b1; lk_vaddr[31:0] = 32'h0080_0004;
    wr_en = 1'b1; wr_random = 1'b0; wr_index = 4'd7; wr_entry = e7;
    #1;
    checkOutput("stall.ready", 128'(lk_ready), 128'(0));
    tick();
    wr_en = 1'b0;
    #1;
    checkOutput("stall.no_response", 128'(rs_valid), 128'(0));
    checkOutput("stall.ready_back", 128'(lk_ready), 128'(2'b11));
    tick();
    lk_valid[0] = 1'b0;
    checkLookup("after_write", 0, 32'h5555_5004, 3'd3, 1'b0, 1'b0, 1'b0);

    // Random register with Wired=4
    wired = 4'd4; wired_wr = 1'b1;
    tick();
    wired_wr = 1'b0;
    checkOutput("random.reload", 128'(random_o), 128'(15));
    for (int k = 1; k <= 10; k++) begin
      tick();
      checkOutput($sformatf("random.step%0d", k), 128'(random_o), 128'(15 - k));
    end
    tick();
    checkOutput("random.wrap", 128'(random_o), 128'(15));
    tick(); tick();
    checkOutput("random.at13", 128'(random_o), 128'(13));
    writeEntry(4'd0, 1'b1, e13);
    rd_index = 4'd13;
    tick();
    checkOutput("tlbwr.idx13", 128'(rd_entry), 128'(e13));
    rd_index = 4'd0;
    tick();
    checkOutput("tlbwr.idx0_untouched", 128'(rd_entry), 128'(0));
    applyStimulus(0, 32'h00A0_0008, 1'b0);
    checkLookup("tlbwr_lookup", 0, 32'h0ABC_D008, 3'd3, 1'b0, 1'b0, 1'b0);
    wired_wr = 1'b1;
    tick();
    wired_wr = 1'b0;
    checkOutput("random.wired_wr", 128'(random_o), 128'(15));
    wired = 4'd15;
    tick(); tick(); tick();
    checkOutput("random.hold", 128'(random_o), 128'(15));
    wired = 4'd0;

    // Unmapped segments
    applyStimulus(0, 32'hA000_0100, 1'b0);
    checkLookup("kseg1", 0, 32'h0000_0100, 3'd2, 1'b0, 1'b0, 1'b0);
    applyStimulus(1, 32'h8000_1234, 1'b1);
    checkLookup("kseg0", 1, 32'h0000_1234, 3'd3, 1'b0, 1'b0, 1'b0);

    // Duplicate mapping: lowest index wins
    writeEntry(4'd1, 1'b0, e1);
    applyStimulus(0, 32'h0080_0004, 1'b0);
    checkLookup("multihit_lowest", 0, 32'h1111_1004, 3'd3, 1'b0, 1'b0, 1'b0);
`ifdef TLB_MULTIHIT_EN
    checkOutput("mc_err.set", 128'(mc_err), 128'(1));
`endif

    // Reset mid-operation drops the in-flight response and clears entries
    lk_valid[0] = 1'b1; lk_vaddr[31:0] = 32'h0080_0004;
    tick();
    lk_valid[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset.rs_valid", 128'(rs_valid), 128'(0));
    checkOutput("midreset.random", 128'(random_o), 128'(15));
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("midreset.after_release", 128'(rs_valid), 128'(0));
    applyStimulus(0, 32'h0080_0004, 1'b0);
    checkLookup("midreset.cleared", 0, 32'h0, 3'd0, 1'b1, 1'b0, 1'b0);
`ifdef TLB_MULTIHIT_EN
    checkOutput("mc_err.cleared", 128'(mc_err), 128'(0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
